kgp_run_monitor: RTL

- Synthesizable run controller and commit monitor for the single-cycle KGP-RISC core; replaces a free-running bench clock/reset stimulus.
- Sequences the core's reset, counts cycles, detects halt (PC stable), enforces a timeout, folds committed results into a signature and buffers committed PCs in a trace FIFO.
- Sits beside the core top level; drives its reset and observes its PC, ALU result and write strobes.

---
 rtl/kgp_run_monitor.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/kgp_run_monitor.sv
// ---------------------------------------------------------------------------
// kgp_run_monitor
// Run controller and commit monitor for the single-cycle KGP-RISC core.
// Sequences the core reset, counts run cycles, detects halt (PC stable for
// HALT_CYCLES cycles), enforces a cycle budget, folds every committed result
// into a rolling signature and buffers committed PCs in a FWFT trace FIFO.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start, i_abort      run control (abort has priority)
//   i_pc, i_alu_result    observed core state
//   i_reg_write/i_mem_write  commit strobes
//   o_core_rst            active-high reset to the core (low only in RUN)
//   o_busy/o_done/o_timeout  run status
//   o_cycle_count, o_commit_count  saturating counters
//   o_signature           rolling commit signature
//   o_trace_pc/o_trace_valid/i_trace_ready  trace FIFO read side
//   o_trace_ovf           sticky: a trace push was dropped
// ---------------------------------------------------------------------------
module kgp_run_monitor #(
  parameter int unsigned      XLEN        = 32,
  parameter int unsigned      DEPTH       = 16,
  parameter int unsigned      RST_CYCLES  = 2,
  parameter int unsigned      HALT_CYCLES = 4,
  parameter int unsigned      MAX_CYCLES  = 1024,
  parameter int unsigned      CNT_W       = 16,
  parameter logic [XLEN-1:0]  SIG_SEED    = 32'hFFFF_FFFF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_alu_result,
  input  logic             i_reg_write,
  input  logic             i_mem_write,
  output logic             o_core_rst,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_cycle_count,
  output logic [CNT_W-1:0] o_commit_count,
  output logic [XLEN-1:0]  o_signature,
  output logic [XLEN-1:0]  o_trace_pc,
  output logic             o_trace_valid,
  input  logic             i_trace_ready,
  output logic             o_trace_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  // Counter widths carry one spare bit so the "+1" constants stay >= 2 bits.
  localparam int unsigned RW = $clog2(RST_CYCLES + 1) + 1;
  localparam int unsigned HW = $clog2(HALT_CYCLES + 1) + 1;

  localparam logic [RW-1:0]    RST_ONE   = {{(RW-1){1'b0}}, 1'b1};
  localparam logic [HW-1:0]    HALT_ONE  = {{(HW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]      PTR_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0]    RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [HW-1:0]    HALT_LAST = HW'(HALT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_CNT   = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  // Signature fold: rotate left by one, then mix in PC and ALU result.
  function automatic logic [XLEN-1:0] sig_fold(input logic [XLEN-1:0] sig,
                                               input logic [XLEN-1:0] pc,
                                               input logic [XLEN-1:0] res);
    return {sig[XLEN-2:0], sig[XLEN-1]} ^ pc ^ res;
  endfunction

  // Saturating increment for the externally visible counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) r = v;
    else    r = v + CNT_ONE;
    return r;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_start_clr;
  logic [RW-1:0]    r_rst_cnt;
  logic [HW-1:0]    r_halt_cnt;
  logic [XLEN-1:0]  r_prev_pc;
  logic             r_prev_valid;
  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_commit_count;
  logic [XLEN-1:0]  r_signature;
  logic             r_core_rst;
  logic             r_busy;
  logic             r_done;
  logic             r_timeout;
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_trace_ovf;
  logic [XLEN-1:0]  r_mem [DEPTH];

  logic             w_run;
  logic             w_commit;
  logic             w_match;
  logic             w_halt;
  logic [CNT_W-1:0] w_cycle_inc;
  logic             w_tmo;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_push_ok;

  assign w_run       = (r_state == ST_RUN);
  assign w_commit    = i_reg_write | i_mem_write;
  // prev_pc is meaningless on the first RUN cycle, hence the valid qualifier.
  assign w_match     = r_prev_valid && (i_pc == r_prev_pc);
  assign w_halt      = w_match && (r_halt_cnt == HALT_LAST);
  assign w_cycle_inc = sat_inc(r_cycle_count);
  // Timeout fires on the edge where the count reaches MAX_CYCLES-1.
  assign w_tmo       = (w_cycle_inc == TMO_CNT);

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push    = w_run && w_commit;
  assign w_pop     = !w_empty && i_trace_ready;
  assign w_push_ok = w_push && (!w_full || w_pop);

  // Next-state logic; abort overrides everything, start only from idle-like states.
  always_comb begin
    w_state_nxt = r_state;
    w_start_clr = 1'b0;
    if (i_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_TIMEOUT: begin
          if (i_start) begin
            w_state_nxt = ST_RESET;
            w_start_clr = 1'b1;
          end else begin
            w_state_nxt = r_state;
          end
        end
        ST_RESET: begin
          if (r_rst_cnt == RST_LAST) w_state_nxt = ST_RUN;
          else                       w_state_nxt = ST_RESET;
        end
        ST_RUN: begin
          if (w_halt)     w_state_nxt = ST_DONE;
          else if (w_tmo) w_state_nxt = ST_TIMEOUT;
          else            w_state_nxt = ST_RUN;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register plus status flags registered from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_core_rst <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_core_rst <= (w_state_nxt != ST_RUN);
      r_busy     <= (w_state_nxt == ST_RESET) || (w_state_nxt == ST_RUN);
      r_done     <= (w_state_nxt == ST_DONE);
      r_timeout  <= (w_state_nxt == ST_TIMEOUT);
    end
  end

  // Run datapath: reset sequencing, counters, halt detection and signature.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rst_cnt      <= '0;
      r_halt_cnt     <= '0;
      r_prev_pc      <= '0;
      r_prev_valid   <= 1'b0;
      r_cycle_count  <= '0;
      r_commit_count <= '0;
      r_signature    <= SIG_SEED;
    end else if (w_start_clr) begin
      r_rst_cnt      <= '0;
      r_halt_cnt     <= '0;
      r_prev_pc      <= '0;
      r_prev_valid   <= 1'b0;
      r_cycle_count  <= '0;
      r_commit_count <= '0;
      r_signature    <= SIG_SEED;
    end else begin
      if (r_state == ST_RESET) begin
        r_rst_cnt <= r_rst_cnt + RST_ONE;
      end
      if (w_run) begin
        r_cycle_count <= w_cycle_inc;
        r_prev_pc     <= i_pc;
        r_prev_valid  <= 1'b1;
        r_halt_cnt    <= w_match ? (r_halt_cnt + HALT_ONE) : '0;
        if (w_commit) begin
          r_signature    <= sig_fold(r_signature, i_pc, i_alu_result);
          r_commit_count <= sat_inc(r_commit_count);
        end
      end
    end
  end

  // Trace FIFO pointers and sticky overflow flag; a start flushes the FIFO.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_trace_ovf <= 1'b0;
    end else if (w_start_clr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_trace_ovf <= 1'b0;
    end else begin
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_push && w_full && !w_pop) r_trace_ovf <= 1'b1;
    end
  end

  // Trace storage; occupancy lives in the pointers so the array needs no reset.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_pc;
  end

  assign o_core_rst     = r_core_rst;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_timeout      = r_timeout;
  assign o_cycle_count  = r_cycle_count;
  assign o_commit_count = r_commit_count;
  assign o_signature    = r_signature;
  assign o_trace_pc     = r_mem[r_rd_ptr[AW-1:0]];
  assign o_trace_valid  = !w_empty;
  assign o_trace_ovf    = r_trace_ovf;

endmodule
